// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one physical-memory line port.
// Optional feature: define CACHE_ARBITER_ROUND_ROBIN_EN for round-robin on simultaneous requests.
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [1:0]            dbg_state_o
);
    // Handshake: a client holds its request until its one-cycle resp pulse; memory holds
    // a strobe until pmem_resp. Strobes and address come only from grant-time registers.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                state_q;
    logic                  rd_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  d_req;
    logic                  gnt_dcache;
    logic                  gnt_icache;
    logic                  unused_addr_bits;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    // 0 = I-cache owned the last transaction, 1 = D-cache.
    logic last_owner_q;
    assign gnt_dcache = d_req & (~i_read | ~last_owner_q);
`else
    assign gnt_dcache = d_req;
`endif
    assign gnt_icache = i_read & ~gnt_dcache;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_dcache) begin
                        state_q <= SERVE_D;
                        addr_q  <= {d_address[ADDR_WIDTH-1:5], 5'b0};
                        rd_q    <= ~d_write;
                        wr_q    <= d_write;
                        if (d_write) wdata_q <= d_wdata;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
                        last_owner_q <= 1'b1;
`endif
                    end else if (gnt_icache) begin
                        state_q <= SERVE_I;
                        addr_q  <= {i_address[ADDR_WIDTH-1:5], 5'b0};
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b0;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
                        last_owner_q <= 1'b0;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q <= IDLE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Responses are combinational with pmem_resp; rdata is only meaningful during resp.
    assign i_resp  = (state_q == SERVE_I) & pmem_resp;
    assign d_resp  = (state_q == SERVE_D) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    assign dbg_state_o      = state_q;
    assign unused_addr_bits = ^{i_address[4:0], d_address[4:0]};
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a small line memory model.
module tb_cache_arbiter;
    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] mem [logic [31:0]];

    cache_arbiter #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Caller raises the request at a negedge; strobe must be up at the next negedge.
    task automatic run_txn(input string tag, input int lat, input logic wr,
                           input logic [31:0] addr, input logic [255:0] wdata,
                           input logic is_i, input logic keep_i, input logic keep_d,
                           input logic perturb);
        logic [255:0] line;
        @(negedge clk);
        chk({tag, "_rd"}, pmem_read, !wr);
        chk({tag, "_wr"}, pmem_write, wr);
        chk({tag, "_addr"}, pmem_address, addr);
        chk({tag, "_state"}, dbg_state, is_i ? 2'd1 : 2'd2);
        chk({tag, "_resp_early"}, {i_resp, d_resp}, 2'b00);
        if (wr) chk({tag, "_wdata"}, pmem_wdata, wdata);
        if (perturb) begin
            d_address = ~d_address;
            d_wdata   = ~d_wdata;
            i_address = ~i_address;
        end
        repeat (lat - 1) @(negedge clk);
        chk({tag, "_hold"}, {pmem_read, pmem_write}, {!wr, wr});
        line = mem.exists(addr) ? mem[addr] : {8{addr}};
        pmem_rdata = line;
        pmem_resp  = 1'b1;
        #1;
        chk({tag, "_i_resp"}, i_resp, is_i);
        chk({tag, "_d_resp"}, d_resp, !is_i);
        chk({tag, "_addr_held"}, pmem_address, addr);
        if (wr) chk({tag, "_wdata_held"}, pmem_wdata, wdata);
        if (!wr) chk({tag, "_rdata"}, is_i ? i_rdata : d_rdata, line);
        if (wr) mem[addr] = wdata;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = {8{$urandom}};
        if (!keep_i) i_read = 1'b0;
        if (!keep_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        #1;
        chk({tag, "_gap_strobes"}, {pmem_read, pmem_write}, 2'b00);
        chk({tag, "_resp_width"}, {i_resp, d_resp}, 2'b00);
        chk({tag, "_idle"}, dbg_state, 2'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        #1;
        chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("rst_addr", pmem_address, 32'h0);
        chk("rst_wdata", pmem_wdata, 256'h0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        chk("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // I read, 5-cycle memory latency, address aligned down
        @(negedge clk);
        i_read = 1'b1; i_address = 32'h0000_1234;
        #1;
        chk("iread_cycle_n", pmem_read, 1'b0);
        run_txn("iread", 5, 1'b0, 32'h0000_1220, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // D writeback then read back the same line
        @(negedge clk);
        d_write = 1'b1; d_address = 32'h0000_8040; d_wdata = {32{8'hA5}};
        run_txn("dwb", 3, 1'b1, 32'h0000_8040, {32{8'hA5}}, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        d_read = 1'b1; d_address = 32'h0000_8047;
        run_txn("dwb_readback", 2, 1'b0, 32'h0000_8040, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dwb_mem", mem[32'h0000_8040], {32{8'hA5}});

        // Simultaneous requests; last owner was D
        @(negedge clk);
        i_read = 1'b1; i_address = 32'h0000_0100;
        d_read = 1'b1; d_address = 32'h0000_0200;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
        run_txn("sim_first_i", 2, 1'b0, 32'h0000_0100, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_txn("sim_then_d", 2, 1'b0, 32'h0000_0200, '0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        run_txn("sim_first_d", 2, 1'b0, 32'h0000_0200, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_txn("sim_then_i", 2, 1'b0, 32'h0000_0100, '0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Read+write both high counts as write; inputs change mid-transaction
        @(negedge clk);
        d_write = 1'b1; d_read = 1'b1; d_address = 32'h0000_3010; d_wdata = {8{32'hDEAD_BEEF}};
        run_txn("perturb", 4, 1'b1, 32'h0000_3000, {8{32'hDEAD_BEEF}}, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during SERVE_I drops strobes asynchronously, then held request regrants
        @(negedge clk);
        i_read = 1'b1; i_address = 32'h0000_4444;
        @(negedge clk);
        chk("rstmid_pre", pmem_read, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_strobe", {pmem_read, pmem_write}, 2'b00);
        chk("rstmid_state", dbg_state, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        run_txn("rstmid_regrant", 2, 1'b0, 32'h0000_4440, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stray pmem_resp in IDLE
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        chk("idle_resp", {i_resp, d_resp}, 2'b00);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk("idle_resp_state", dbg_state, 2'd0);
        chk("idle_resp_strobes", {pmem_read, pmem_write}, 2'b00);

        // Two D reads back-to-back with one low cycle between
        @(negedge clk);
        d_read = 1'b1; d_address = 32'h0000_5000;
        run_txn("b2b_0", 3, 1'b0, 32'h0000_5000, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        d_address = 32'h0000_6000;
        run_txn("b2b_1", 3, 1'b0, 32'h0000_6000, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates between the instruction-cache and data-cache line ports of the pipelined core and a single physical-memory line port. Serializes 256-bit line reads and writebacks, owns the memory port for exactly one transaction per grant, and routes the response back to the requesting cache. Sits directly between the core's two caches and `physical_memory`.

## Interface
- `LINE_WIDTH`, 256: cache line width in bits.
- `ADDR_WIDTH`, 32: byte address width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_read`  in  1  I-cache line read request; held until `i_resp`.
- `i_address`  in  ADDR_WIDTH  I-cache line address.
- `i_rdata`  out  LINE_WIDTH  line returned to I-cache.
- `i_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_read`  in  1  D-cache line read request; held until `d_resp`.
- `d_write`  in  1  D-cache writeback request; held until `d_resp`.
- `d_address`  in  ADDR_WIDTH  D-cache line address.
- `d_wdata`  in  LINE_WIDTH  writeback line.
- `d_rdata`  out  LINE_WIDTH  line returned to D-cache.
- `d_resp`  out  1  one-cycle completion pulse to D-cache.
- `pmem_read`, `pmem_write`  out  1  memory request strobes.
- `pmem_address`  out  ADDR_WIDTH  line-aligned memory address.
- `pmem_wdata`  out  LINE_WIDTH  writeback data to memory.
- `pmem_rdata`  in  LINE_WIDTH  line from memory.
- `pmem_resp`  in  1  memory completion pulse.

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`. Reset state `IDLE`.
- `IDLE`: if a D request (`d_read | d_write`) is pending, go to `SERVE_D`; else if `i_read`, go to `SERVE_I`; else stay. D wins simultaneous requests (default fixed priority).
- On grant, register owner's address as `{addr[ADDR_WIDTH-1:5], 5'b0}`, the operation (read/write), and `d_wdata` for writes. Memory-side outputs come only from these registers, so changes on client inputs mid-transaction do not reach memory.
- `d_read` and `d_write` both high: treated as a write.
- `SERVE_x`: assert `pmem_read` or `pmem_write` per the latched op. On `pmem_resp`, pulse owner's `*_resp` in the same cycle with `*_rdata = pmem_rdata` (read) and return to `IDLE`.
- Non-owner `*_resp` is always 0. `i_rdata`/`d_rdata` pass `pmem_rdata` unconditionally. Clients sample rdata only on resp.
- Client dropping its request mid-transaction: the transaction still completes, and the resp pulse is still issued.
- `pmem_resp` in `IDLE`: ignored, no client resp.

## Timing
- Reset values: `pmem_read=0`, `pmem_write=0`, `pmem_address=0`, `pmem_wdata=0`, `i_resp=0`, `d_resp=0`. State `IDLE`. Reset asserted mid-transaction drops strobes immediately, without waiting for a clock edge.
- Request visible in cycle N while in `IDLE` → strobe asserted in cycle N+1.
- `pmem_resp` in cycle M → client resp in cycle M, combinational. `IDLE` in cycle M+1 with strobes low.
- Mandatory one-cycle `IDLE` turnaround between transactions. Strobes are never high in two consecutive transactions without a low cycle between them.
- Back-to-back throughput: one transaction per (memory latency + 1) cycles.
- Client resp is 1 cycle wide. Clients deassert or change requests in cycle M+1 at the earliest.

## Configuration
- `CACHE_ARBITER_ROUND_ROBIN_EN` defined: a 1-bit `last_owner` register (reset = I) is added. On simultaneous requests in `IDLE`, grant goes to the port that did not own the previous transaction. A single request is always granted immediately.
- Macro undefined: fixed D-over-I priority, and no `last_owner` register.

## Test plan
- I read only: `i_read=1`, `i_address=0x0000_1234`; memory responds after 5 cycles. Required: `pmem_read` high from N+1, `pmem_address=0x0000_1220`, `i_resp` pulses with `i_rdata` = memory line, `d_resp` stays 0.
- D writeback: `d_write=1`, `d_address=0x0000_8040`, `d_wdata` = pattern `0xA5…`. Required: `pmem_write` with matching address and data. `d_resp` pulses once. Memory contents are verified by a later read.
- Simultaneous `i_read` and `d_read` in the same cycle, macro undefined. Required: D is served first, then I after one `IDLE` cycle. With the macro defined, after a prior D transaction, I is served first.
- Input change mid-transaction: alter `d_address` and `d_wdata` while `SERVE_D` is active. Required: `pmem_address` and `pmem_wdata` hold the values latched at grant.
- Reset mid-transaction: assert `rst` during `SERVE_I`. Required: strobes go to 0 asynchronously and the FSM is in `IDLE`. After reset deasserts, a held `i_read` is re-granted and completes.
- Two D reads queued back-to-back: the strobe shows a 1-cycle low gap between them, and each `d_resp` is exactly 1 cycle.
